// File: rtl/target_track_pkg.sv
// Shared definitions for the target track predictor: mode encodings,
// controller state type and the unsigned saturation helper.
package target_track_pkg;

  localparam logic [1:0] MODE_PASS    = 2'b00;
  localparam logic [1:0] MODE_PREDICT = 2'b01;
  localparam logic [1:0] MODE_HOLD    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CALC    = 2'd1,
    ST_PRESENT = 2'd2
  } state_t;

  // Saturate a signed value into the unsigned range [0, 2^w - 1].
  function automatic logic [31:0] clamp_unsigned(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< w) - 32'sd1;
    if (v < 32'sd0)
      return '0;
    if (v > hi)
      return $unsigned(hi);
    return $unsigned(v);
  endfunction

endpackage

// File: rtl/track_channel.sv
// One coordinate axis: DEPTH-entry history ring plus the velocity and
// extrapolation datapath that works on the newest and LAG-old samples.
module track_channel
  import target_track_pkg::*;
#(
  parameter int COORD_W       = 8,
  parameter int DEPTH         = 8,
  parameter int LAG           = 2,
  parameter int VEL_SHIFT     = 4,
  parameter int HORIZON_SHIFT = 2,
  parameter int DEADBAND      = 1
) (
  input  logic                       clk50mhz,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
  input  logic [COORD_W-1:0]         wr_data,
  output logic [COORD_W-1:0]         newest,
  output logic [COORD_W-1:0]         pred,
  output logic                       moving
);

  localparam int PTR_W = $clog2(DEPTH);

  logic        [COORD_W-1:0] ring [DEPTH];
  logic        [PTR_W-1:0]   new_ptr;
  logic        [PTR_W-1:0]   lag_ptr;
  logic        [COORD_W-1:0] lagged;
  logic signed [COORD_W:0]   dx;
  logic signed [COORD_W:0]   vx;
  logic        [COORD_W:0]   vx_mag;
  logic signed [COORD_W+1:0] vx_ext;
  logic signed [COORD_W+1:0] pred_wide;

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else if (wr_en) begin
      ring[wr_ptr] <= wr_data;
    end
  end

  // The write pointer already points past the newest entry; wrap is mod DEPTH.
  assign new_ptr = wr_ptr - PTR_W'(1);
  assign lag_ptr = wr_ptr - PTR_W'(LAG + 1);
  assign newest  = ring[new_ptr];
  assign lagged  = ring[lag_ptr];

  assign dx        = $signed({1'b0, newest}) - $signed({1'b0, lagged});
  assign vx        = dx >>> VEL_SHIFT;
  assign vx_mag    = vx[COORD_W] ? $unsigned(-vx) : $unsigned(vx);
  assign moving    = vx_mag > $unsigned((COORD_W+1)'(DEADBAND));
  assign vx_ext    = (COORD_W+2)'(vx);
  assign pred_wide = $signed({2'b00, newest}) + (vx_ext <<< HORIZON_SHIFT);
  assign pred      = COORD_W'(clamp_unsigned(32'(pred_wide), COORD_W));

endmodule

// File: rtl/target_track_predictor.sv
// Multi-channel target predictor: assembles frames from a byte stream, keeps
// per-channel history and presents a raw or extrapolated frame on valid/ready.
module target_track_predictor
  import target_track_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int COORD_W       = 8,
  parameter int DEPTH         = 8,
  parameter int LAG           = 2,
  parameter int VEL_SHIFT     = 4,
  parameter int HORIZON_SHIFT = 2,
  parameter int DEADBAND      = 1,
  parameter int FRAME_GAP     = 1_000_000
) (
  input  logic                          clk50mhz,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [COORD_W-1:0]            in_data,
  input  logic [1:0]                    mode,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHANNELS*COORD_W-1:0]   out_data,
  output logic                          out_predicted,
  output logic                          hist_full,
  output logic                          overrun,
  output logic                          frame_abort
);

  localparam int IDX_W   = $clog2(CHANNELS);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int GAP_W   = $clog2(FRAME_GAP + 1);
  localparam int FRAME_W = CHANNELS * COORD_W;

  logic [IDX_W-1:0]    idx;
  logic [FRAME_W-1:0]  part_buf;
  logic [GAP_W-1:0]    gap_cnt;
  logic [PTR_W-1:0]    wr_ptr;
  logic [CNT_W-1:0]    count;
  logic [FRAME_W-1:0]  frame_vec;
  logic [FRAME_W-1:0]  newest_vec;
  logic [FRAME_W-1:0]  pred_vec;
  logic [CHANNELS-1:0] moving_vec;
  logic                frame_done;
  logic                dup;
  logic                commit;
  logic                gap_hit;
  logic                predict_en;
  logic                ovr_set;
  state_t              state;
  state_t              state_nxt;

  // The last byte of a frame is used straight from the input so the frame
  // commits on the same edge that samples it.
  always_comb begin
    frame_vec = part_buf;
    frame_vec[FRAME_W-1 -: COORD_W] = in_data;
  end

  assign frame_done = in_valid && (idx == IDX_W'(CHANNELS - 1));
  assign dup        = (count != '0) && (frame_vec == newest_vec);
  assign commit     = frame_done && !dup && !flush;
  assign gap_hit    = !in_valid && (idx != '0) && (gap_cnt == GAP_W'(FRAME_GAP - 1));

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      part_buf    <= '0;
      gap_cnt     <= '0;
      frame_abort <= 1'b0;
    end else begin
      frame_abort <= 1'b0;
      if (flush) begin
        idx      <= '0;
        part_buf <= '0;
        gap_cnt  <= '0;
      end else if (in_valid) begin
        gap_cnt <= '0;
        part_buf[idx*COORD_W +: COORD_W] <= in_data;
        idx     <= frame_done ? '0 : idx + IDX_W'(1);
      end else if (idx != '0) begin
        if (gap_hit) begin
          idx         <= '0;
          gap_cnt     <= '0;
          frame_abort <= 1'b1;
        end else begin
          gap_cnt <= gap_cnt + GAP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (commit) begin
      wr_ptr <= wr_ptr + PTR_W'(1);
      if (count != CNT_W'(DEPTH)) count <= count + CNT_W'(1);
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    track_channel #(
      .COORD_W      (COORD_W),
      .DEPTH        (DEPTH),
      .LAG          (LAG),
      .VEL_SHIFT    (VEL_SHIFT),
      .HORIZON_SHIFT(HORIZON_SHIFT),
      .DEADBAND     (DEADBAND)
    ) u_ch (
      .clk50mhz(clk50mhz),
      .rst_n   (rst_n),
      .clr     (flush),
      .wr_en   (commit),
      .wr_ptr  (wr_ptr),
      .wr_data (frame_vec[k*COORD_W +: COORD_W]),
      .newest  (newest_vec[k*COORD_W +: COORD_W]),
      .pred    (pred_vec[k*COORD_W +: COORD_W]),
      .moving  (moving_vec[k])
    );
  end

  assign predict_en = (mode == MODE_PREDICT) && (count > CNT_W'(LAG)) && (|moving_vec);

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      overrun <= ovr_set;
    end
  end

  // A commit during CALC re-runs CALC so the freshest frame is the one presented.
  always_comb begin
    state_nxt = state;
    ovr_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (commit) state_nxt = ST_CALC;
      end
      ST_CALC: begin
        if (commit)                 state_nxt = ST_CALC;
        else if (mode == MODE_HOLD) state_nxt = ST_IDLE;
        else                        state_nxt = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (commit) begin
          state_nxt = ST_CALC;
          ovr_set   = 1'b1;
        end else if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      ovr_set   = 1'b0;
    end
  end

  always_ff @(posedge clk50mhz or negedge rst_n) begin
    if (!rst_n) begin
      out_data      <= '0;
      out_predicted <= 1'b0;
    end else if (state == ST_CALC) begin
      out_data      <= predict_en ? pred_vec : newest_vec;
      out_predicted <= predict_en;
    end
  end

  assign out_valid = (state == ST_PRESENT);
  assign hist_full = (count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_target_track_predictor.sv
// Directed bench for target_track_predictor: frame assembly, prediction,
// clamping, dedup, overrun, gap abort, hold mode, flush and reset.
module tb_target_track_predictor;

  localparam int GAP = 16;

  logic        clk50mhz;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic [1:0]  mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_predicted;
  logic        hist_full;
  logic        overrun;
  logic        frame_abort;

  int n_checks;
  int n_fail;
  int ovr_cnt;
  int abort_cnt;
  int vld_seen;
  int base;

  target_track_predictor #(
    .CHANNELS     (2),
    .COORD_W      (8),
    .DEPTH        (8),
    .LAG          (2),
    .VEL_SHIFT    (4),
    .HORIZON_SHIFT(2),
    .DEADBAND     (1),
    .FRAME_GAP    (GAP)
  ) dut (
    .clk50mhz     (clk50mhz),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .mode         (mode),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_predicted(out_predicted),
    .hist_full    (hist_full),
    .overrun      (overrun),
    .frame_abort  (frame_abort)
  );

  initial clk50mhz = 1'b0;
  always #5 clk50mhz = ~clk50mhz;

  initial begin
    ovr_cnt   = 0;
    abort_cnt = 0;
    vld_seen  = 0;
  end

  always @(negedge clk50mhz) begin
    if (overrun)     ovr_cnt   = ovr_cnt + 1;
    if (frame_abort) abort_cnt = abort_cnt + 1;
    if (out_valid)   vld_seen  = vld_seen + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk50mhz);
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk50mhz);
    in_data  = b;
    @(negedge clk50mhz);
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                            input logic prd);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk50mhz);
      if (out_valid) break;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), {16'd0, c1, c0});
    check_eq({tag, "_pred"}, 32'(out_predicted), 32'(prd));
  endtask

  task automatic do_flush();
    @(negedge clk50mhz);
    flush = 1'b1;
    @(negedge clk50mhz);
    flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    mode      = 2'b01;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk50mhz);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_pred", 32'(out_predicted), 32'd0);
    check_eq("rst_full", 32'(hist_full), 32'd0);
    check_eq("rst_ovr", 32'(overrun), 32'd0);
    check_eq("rst_abort", 32'(frame_abort), 32'd0);
    rst_n = 1'b1;

    // Linear prediction: 140 + ((40 >>> 4) <<< 2) = 148
    send_frame(8'd100, 8'd50);
    expect_out("lin1", 8'd100, 8'd50, 1'b0);
    send_frame(8'd120, 8'd50);
    expect_out("lin2", 8'd120, 8'd50, 1'b0);
    send_frame(8'd140, 8'd50);
    expect_out("lin3", 8'd148, 8'd50, 1'b1);

    // Duplicate frame is dropped
    send_frame(8'd140, 8'd50);
    base = vld_seen;
    repeat (6) @(negedge clk50mhz);
    check_eq("dup_novalid", 32'(vld_seen - base), 32'd0);
    check_eq("dup_count", 32'(dut.count), 32'd3);

    // Clamp high: 250 + 12 = 262 -> 255
    do_flush();
    check_eq("flush_count", 32'(dut.count), 32'd0);
    send_frame(8'd200, 8'd9);
    expect_out("hi1", 8'd200, 8'd9, 1'b0);
    send_frame(8'd230, 8'd9);
    expect_out("hi2", 8'd230, 8'd9, 1'b0);
    send_frame(8'd250, 8'd9);
    expect_out("hi3", 8'd255, 8'd9, 1'b1);

    // Clamp low: dx = -50, vx = -4, 0 - 16 -> 0
    do_flush();
    send_frame(8'd50, 8'd9);
    expect_out("lo1", 8'd50, 8'd9, 1'b0);
    send_frame(8'd20, 8'd9);
    expect_out("lo2", 8'd20, 8'd9, 1'b0);
    send_frame(8'd0, 8'd9);
    expect_out("lo3", 8'd0, 8'd9, 1'b1);

    // Overrun: |vx| = 1 stays inside the deadband, so both results are raw
    @(negedge clk50mhz);
    out_ready = 1'b0;
    base = ovr_cnt;
    send_frame(8'd10, 8'd9);
    expect_out("ovr1", 8'd10, 8'd9, 1'b0);
    repeat (2) @(negedge clk50mhz);
    check_eq("ovr_stable", 32'(out_data), 32'h0000_090A);
    send_frame(8'd30, 8'd9);
    expect_out("ovr2", 8'd30, 8'd9, 1'b0);
    check_eq("ovr_pulses", 32'(ovr_cnt - base), 32'd1);
    out_ready = 1'b1;
    @(negedge clk50mhz);
    check_eq("ovr_accept", 32'(out_valid), 32'd0);

    // Gap abort, then a fresh frame starts at channel 0
    do_flush();
    base = abort_cnt;
    @(negedge clk50mhz);
    in_valid = 1'b1;
    in_data  = 8'd77;
    @(negedge clk50mhz);
    in_valid = 1'b0;
    repeat (GAP + 4) @(negedge clk50mhz);
    check_eq("abort_pulse", 32'(abort_cnt - base), 32'd1);
    send_frame(8'd10, 8'd20);
    expect_out("post_abort", 8'd10, 8'd20, 1'b0);

    // Hold mode: history fills but nothing is presented
    do_flush();
    mode = 2'b10;
    base = vld_seen;
    for (int k = 0; k < 8; k++) begin
      send_frame(8'(k * 10 + 1), 8'(k));
      repeat (2) @(negedge clk50mhz);
      if (k == 6) check_eq("hold_full7", 32'(hist_full), 32'd0);
    end
    check_eq("hold_full8", 32'(hist_full), 32'd1);
    check_eq("hold_novalid", 32'(vld_seen - base), 32'd0);
    do_flush();
    check_eq("hold_flush_full", 32'(hist_full), 32'd0);
    check_eq("hold_flush_count", 32'(dut.count), 32'd0);

    // Reset while presenting and mid-frame
    mode      = 2'b00;
    out_ready = 1'b0;
    send_frame(8'd33, 8'd44);
    expect_out("pre_rst", 8'd33, 8'd44, 1'b0);
    @(negedge clk50mhz);
    in_valid = 1'b1;
    in_data  = 8'd99;
    @(negedge clk50mhz);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_data", 32'(out_data), 32'd0);
    @(negedge clk50mhz);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    send_frame(8'd60, 8'd70);
    expect_out("post_rst", 8'd60, 8'd70, 1'b0);

    repeat (2) @(negedge clk50mhz);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
